// File: rtl/fsm_pkg.sv
// Shared definitions for the unscale FSM: state encoding, stage count and
// the result-width helper.
package fsm_pkg;

    // Number of halving steps; together they divide the sample by 16.
    localparam int unsigned NUM_STAGES = 4;

    // Unused codes 3'b101..3'b111 recover to IDLE on the next edge.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        STAGE1 = 3'b001,
        STAGE2 = 3'b010,
        STAGE3 = 3'b011,
        STAGE4 = 3'b100
    } state_t;

    // Result width for a given WIDTH parameter; matches the doubling chain's a width.
    function automatic int unsigned out_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/fsm_halve_stage.sv
// Combinational halving step used once per FSM stage.
// Config macro: FSM_UNSCALE_ROUND_EN selects round-half-up, (x+1)>>1;
// otherwise the step truncates, x>>1.
module fsm_halve_stage #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    // One extra guard bit holds the rounding carry, so x+1 never wraps.
    logic [W:0] sum;

    // Optional round-up, then shift right by one.
    always_comb begin
`ifdef FSM_UNSCALE_ROUND_EN
        sum = {1'b0, x} + {{W{1'b0}}, 1'b1};
`else
        sum = {1'b0, x};
`endif
        y = W'(sum >> 1);
    end

endmodule

// File: rtl/fsm_unscale.sv
// Iterative divide-by-16 of a scaled sample through four halving states,
// with a start/busy/done handshake. One sample in flight at a time.
// Config macro: FSM_UNSCALE_ROUND_EN enables rounding in every halving
// step and lets the result saturate; without it sat stays 0.
module fsm_unscale
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH+4:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   dout,
    output logic             sat
);

    localparam int unsigned IW = WIDTH + 5;
    localparam int unsigned OW = out_width(WIDTH);

    state_t        state;
    logic [IW-1:0] acc;
    logic [IW-1:0] half;
    logic          ovf;
    logic [OW-1:0] res;

    // A single halving stage is shared by every state and always works on acc.
    fsm_halve_stage #(
        .W(IW)
    ) u_halve (
        .x(acc),
        .y(half)
    );

    // Clamp the final halved value to the result width.
    always_comb begin
        ovf = |half[IW-1:OW];
        res = ovf ? '1 : half[OW-1:0];
    end

    // Sequencer: capture on start, halve three times, then halve, clamp and publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
            sat   <= 1'b0;
        end else begin
            done <= 1'b0;
            sat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= din;
                        busy  <= 1'b1;
                        state <= STAGE1;
                    end
                end
                STAGE1: begin
                    acc   <= half;
                    state <= STAGE2;
                end
                STAGE2: begin
                    acc   <= half;
                    state <= STAGE3;
                end
                STAGE3: begin
                    acc   <= half;
                    state <= STAGE4;
                end
                STAGE4: begin
                    dout  <= res;
`ifdef FSM_UNSCALE_ROUND_EN
                    sat   <= ovf;
`else
                    sat   <= 1'b0;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_unscale.sv
// Directed self-checking bench for fsm_unscale (WIDTH=4).
// Expected values follow FSM_UNSCALE_ROUND_EN when it is defined.
module tb_fsm_unscale;
    import fsm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] din;
    logic       busy;
    logic       done;
    logic [4:0] dout;
    logic       sat;

    int unsigned checks;
    int unsigned failures;

    fsm_unscale #(
        .WIDTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .din  (din),
        .busy (busy),
        .done (done),
        .dout (dout),
        .sat  (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one sample at the current negedge and check the whole transaction.
    task automatic run(input string tag, input logic [8:0] value,
                       input logic [31:0] exp_dout, input logic [31:0] exp_sat);
        start = 1'b1;
        din   = value;
        @(negedge clk);
        check({tag, "_accept_busy"}, busy, 1);
        check({tag, "_accept_done"}, done, 0);
        start = 1'b0;
        din   = ~value;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_stage_busy"}, busy, 1);
            check({tag, "_stage_done"}, done, 0);
        end
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_dout"}, dout, exp_dout);
        check({tag, "_sat"}, sat, exp_sat);
        @(negedge clk);
        check({tag, "_done_clear"}, done, 0);
        check({tag, "_sat_clear"}, sat, 0);
        check({tag, "_dout_hold"}, dout, exp_dout);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        din      = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_sat", sat, 0);
        check("rst_state", dut.state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run("d160", 9'd160, 10, 0);
`ifdef FSM_UNSCALE_ROUND_EN
        run("d24", 9'd24, 2, 0);
        run("d511", 9'd511, 31, 1);
`else
        run("d24", 9'd24, 1, 0);
        run("d511", 9'd511, 31, 0);
`endif

        // start held high: accepts at edges 0 and 5, ignored while busy
        start = 1'b1;
        din   = 9'd48;
        @(negedge clk);
        check("bb_acc0_busy", busy, 1);
        din = 9'd80;
        repeat (3) @(negedge clk);
        check("bb_mid_busy", busy, 1);
        @(negedge clk);
        check("bb_done0", done, 1);
        check("bb_dout0", dout, 3);
        check("bb_busy0", busy, 0);
        @(negedge clk);
        check("bb_acc1_busy", busy, 1);
        check("bb_acc1_done", done, 0);
        check("bb_dout_hold", dout, 3);
        din = 9'd200;
        repeat (3) @(negedge clk);
        check("bb_mid1_done", done, 0);
        @(negedge clk);
        check("bb_done1", done, 1);
        check("bb_dout1", dout, 5);
        start = 1'b0;
        @(negedge clk);
        check("bb_idle_busy", busy, 0);
        check("bb_idle_done", done, 0);
        check("bb_idle_dout", dout, 5);

        // reset during STAGE2 discards the sample
        start = 1'b1;
        din   = 9'd200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_state", dut.state, STAGE2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_sat", sat, 0);
        check("mid_rst_state", dut.state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        run("d32", 9'd32, 2, 0);

        // illegal state code recovers to IDLE with outputs untouched
        force dut.state = state_t'(3'b101);
        #1;
        release dut.state;
        check("ill_state_set", dut.state, 3'b101);
        @(negedge clk);
        check("ill_state_idle", dut.state, IDLE);
        check("ill_dout", dout, 2);
        check("ill_busy", busy, 0);
        check("ill_done", done, 0);
        check("ill_sat", sat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
